serial_adder_ctrl: RTL

Bit-serial adder/subtractor. It sequences one 1-bit full-adder slice (sum = a^b^c, carry = (a^b)&c | a&b) over WIDTH clock cycles, LSB first, with a registered carry between bits. A start/busy/done handshake loads the operands and returns a registered WIDTH-bit result with carry-out and signed overflow. It is the area-minimal alternative to a ripple-carry adder in the combinational-logic library.

---
 rtl/serial_adder_ctrl_if.sv | 43 ++++
 rtl/serial_adder_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : Handshake and operand/result bundle for the bit-serial
//               adder/subtractor.
//               master : drives start/sub/a/b/cin, observes busy/done/results
//               slave  : the adder core
//   start    request, sampled only while the core is idle
//   sub      0 = a+b+cin, 1 = a-b
//   a, b     operands (WIDTH bits)
//   cin      carry-in for add
//   busy     high while the core is shifting bits
//   done     one-cycle completion pulse
//   sum      registered WIDTH-bit result
//   cout     final carry-out (subtract: 1 = no borrow)
//   overflow signed overflow of the last operation
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, cout, overflow
   );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder/subtractor. A single full-adder slice is
//               stepped over WIDTH clock cycles, LSB first, with a registered
//               carry between bits. Results are published only when the last
//               bit has been processed.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - serial_adder_ctrl_if.slave (start/sub/a/b/cin in,
//                      busy/done/sum/cout/overflow out)
// Parameters  : WIDTH - operand/result width, 1..32
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  wire logic          clk,
   input  wire logic          rst,
   serial_adder_ctrl_if.slave bus
);

   localparam int               CNT_W  = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_shift;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_overflow;
   logic             r_busy;
   logic             r_done;

   logic             w_sum_bit;
   logic             w_carry_next;
   logic [WIDTH-1:0] w_shift_next;

   // Full-adder slice on the current LSBs, and the result shift register with
   // the new bit entering at the MSB (works for WIDTH = 1 as well).
   always_comb begin
      w_sum_bit               = r_op_a[0] ^ r_op_b[0] ^ r_carry;
      w_carry_next            = ((r_op_a[0] ^ r_op_b[0]) & r_carry) | (r_op_a[0] & r_op_b[0]);
      w_shift_next            = r_shift >> 1;
      w_shift_next[WIDTH-1]   = w_sum_bit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_shift    <= '0;
         r_carry    <= 1'b0;
         r_cnt      <= '0;
         r_sum      <= '0;
         r_cout     <= 1'b0;
         r_overflow <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  // Subtraction is a + ~b + 1; cin has no effect then.
                  r_op_a  <= bus.a;
                  r_op_b  <= bus.sub ? ~bus.b : bus.b;
                  r_carry <= bus.sub ? 1'b1 : bus.cin;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end

            S_RUN: begin
               r_shift <= w_shift_next;
               r_op_a  <= r_op_a >> 1;
               r_op_b  <= r_op_b >> 1;
               r_carry <= w_carry_next;
               if (r_cnt == C_LAST) begin
                  // r_carry here is the carry into the MSB.
                  r_sum      <= w_shift_next;
                  r_cout     <= w_carry_next;
                  r_overflow <= r_carry ^ w_carry_next;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.sum      = r_sum;
   assign bus.cout     = r_cout;
   assign bus.overflow = r_overflow;

endmodule
`default_nettype wire
